// File: rtl/rf_mp.sv
// ---------------------------------------------------------------------------
// rf_mp : parametrised multi-port register file
//
// Sits between decode and the ALU / memory writeback stage. It has NRD
// registered read ports, two write ports, write-to-read bypass, an optional
// hardwired zero register and a clear sequencer. The sequencer zeroes every
// entry after reset and whenever clr_req is pulsed while idle.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   rd_en     per-port read enable                        [NRD]
//   rd_addr   read addresses, port k at [k*AW +: AW]      [NRD*AW]
//   rd_data   registered read data, port k at [k*DW +: DW][NRD*DW]
//   wr_en     write enables for write ports 0 and 1       [2]
//   wr_addr   write addresses, port w at [w*AW +: AW]     [2*AW]
//   wr_data   write data, port w at [w*DW +: DW]          [2*DW]
//   clr_req   single-cycle pulse that starts a bulk clear
//   clr_busy  high while the clear sequencer runs
// ---------------------------------------------------------------------------
module rf_mp #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic [1:0]        wr_en,
    input  logic [2*AW-1:0]   wr_addr,
    input  logic [2*DW-1:0]   wr_data,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   ptr_reg;
    logic            clr_busy_reg;

    // Storage has no reset. The clear sequencer zeroes it after reset.
    logic [DW-1:0]   mem [DEPTH];

    // Per-write-port decode. wr_ok already folds in the IDLE-only rule and
    // the zero-register discard, so write and bypass logic share one qualifier.
    logic [1:0]      wr_ok;
    logic [AW-1:0]   wa [2];
    logic [DW-1:0]   wd [2];

    // ------------------------------------------------------------------
    // Clear sequencer. clr_req is only looked at in IDLE, so a request
    // that arrives mid-clear never restarts the pointer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            ptr_reg      <= '0;
            clr_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_req) begin
                        state_reg    <= CLEAR;
                        ptr_reg      <= '0;
                        clr_busy_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr_reg <= ptr_reg + 1'b1;
                    if (&ptr_reg) begin
                        state_reg    <= IDLE;
                        clr_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    clr_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_reg;

    // ------------------------------------------------------------------
    // Write port decode
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr
            assign wa[gi]    = wr_addr[gi*AW +: AW];
            assign wd[gi]    = wr_data[gi*DW +: DW];
            assign wr_ok[gi] = wr_en[gi] && (state_reg == IDLE) &&
                               !((ZERO_R0 != 0) && (wa[gi] == '0));
        end
    endgenerate

    // Port 1 is applied second, so it wins when both ports hit one address.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[ptr_reg] <= '0;
        end else begin
            if (wr_ok[0]) mem[wa[0]] <= wd[0];
            if (wr_ok[1]) mem[wa[1]] <= wd[1];
        end
    end

    // ------------------------------------------------------------------
    // Read ports: independent registered reads with write bypass
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic [DW-1:0] rd_next;
            logic [DW-1:0] rd_data_reg;

            assign ra = rd_addr[gi*AW +: AW];

            // Later assignments have higher priority. The clear override
            // comes last. The zero-register override only matters for
            // entry 0 itself. Writes to entry 0 never qualify in wr_ok, but
            // the stored word there may be uninitialised until the first
            // clear, so the override is still needed.
            always_comb begin
                rd_next = mem[ra];
                if (wr_ok[0] && (wa[0] == ra)) rd_next = wd[0];
                if (wr_ok[1] && (wa[1] == ra)) rd_next = wd[1];
                if ((ZERO_R0 != 0) && (ra == '0)) rd_next = '0;
                if (state_reg == CLEAR) rd_next = '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_reg <= '0;
                end else if (rd_en[gi]) begin
                    rd_data_reg <= rd_next;
                end
            end

            assign rd_data[gi*DW +: DW] = rd_data_reg;
        end
    endgenerate

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port register file; next generation of the SISC register file.
- Sits between decode and the ALU/memory writeback stage.
- Registered reads, two write ports, write-to-read bypass and an optional hardwired zero register.
- Built-in clear sequencer that zeroes the array after reset or on request.

Parameters:
DW, 32, data width in bits
AW, 4, address width; depth = 2**AW entries
NRD, 2, number of read ports
ZERO_R0, 1, when 1 entry 0 always reads as zero and ignores writes

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rd_en  input  NRD  per-port read enable
rd_addr  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NRD*DW  registered read data; port k at bits [k*DW +: DW]
wr_en  input  2  write enables for write ports 0 and 1
wr_addr  input  2*AW  write addresses; port w at bits [w*AW +: AW]
wr_data  input  2*DW  write data; port w at bits [w*DW +: DW]
clr_req  input  1  single-cycle pulse that starts a bulk clear
clr_busy  output  1  high while the clear sequencer runs

Behaviour:
Reset:
- rst_n low asynchronously forces rd_data to 0, the FSM to CLEAR, the clear pointer to 0 and clr_busy to 1.
- Array contents are not reset directly; the sequencer zeroes them after release.

FSM states IDLE and CLEAR:
- CLEAR: each cycle writes 0 to entry[ptr], then ptr increments.
- After writing entry 2**AW-1, go to IDLE next cycle. Clear takes exactly 2**AW cycles.
- During CLEAR: wr_en is ignored, clr_busy = 1, and any enabled read port loads 0.
- IDLE: clr_req = 1 moves to CLEAR with ptr = 0 next cycle.
- clr_req during CLEAR is ignored; it does not restart the pointer.

Reads:
- Latency 1. If rd_en[k] is high at edge t, rd_data[k] is valid after edge t and holds until the next enabled read.
- If rd_en[k] is low, rd_data[k] holds its value.
- ZERO_R0 = 1 and rd_addr = 0 gives 0.

Writes (IDLE only):
- Each enabled port writes wr_data to wr_addr at the edge.
- Writes to entry 0 are discarded when ZERO_R0 = 1.
- Both ports targeting the same address: port 1 wins.

Bypass:
- A read and a write to the same address in the same cycle return the new write data, not the stale entry.
- Port 1 data takes precedence if both write ports match.
- No bypass to entry 0 when ZERO_R0 = 1.
- No bypass during CLEAR; reads return 0 there.

General:
- All read ports are independent, and any number may read the same address.
- Widths are exact: no truncation or extension internally.
- Out-of-range addresses are impossible, since depth is 2**AW.

Test Plan:
1. Reset then clear: pulse rst_n low, release, then read all 16 entries after clr_busy falls -> clr_busy high for exactly 16 cycles after release, and every read is 0x00000000.
2. Basic write/read: write 0xDEADBEEF to r5 via port 0, read r5 on both read ports next cycle -> both rd_data = 0xDEADBEEF one cycle after the read edge.
3. Bypass: write 0x12345678 to r7 while reading r7 in the same cycle (r7 previously 0xAAAA0000) -> rd_data = 0x12345678.
4. Write conflict: same cycle, port 0 writes 0x11111111 and port 1 writes 0x22222222 to r3, with a bypass read of r3 -> bypass returns 0x22222222 and a later read returns 0x22222222.
5. Zero register: write 0xFFFFFFFF to r0 via either port while reading r0 -> 0 now and on a later read.
6. Mid-run clear: fill r1..r15 with nonzero values, pulse clr_req, attempt a write to r9 during CLEAR, pulse clr_req again at cycle 8 -> clr_busy lasts 16 cycles, the write is dropped and all entries read 0 afterwards.
